// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz vector sequencer and its MISR.
// The tag index is a fixed 16-bit field; the top keeps only the low bits it needs.
package fuzz_seq_pkg;

    localparam int DEF_IN_W  = 76;
    localparam int DEF_OUT_W = 240;
    localparam int TAG_IDX_W = 16;

    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } seq_tag_t;

endpackage

// File: rtl/fuzz_vec_sequencer_sig_misr.sv
// Folds a wide output bus into 32 bits and accumulates it into a CRC-32 style MISR.
module sig_misr
    import fuzz_seq_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [31:0]      sig
);

    localparam int NW = (OUT_W + 31) / 32;

    logic [NW*32-1:0] padded;
    logic [31:0]      fold;
    logic [31:0]      sig_next;

    always_comb begin
        padded = '0;
        padded[OUT_W-1:0] = data;
        fold = '0;
        for (int i = 0; i < NW; i++) begin
            fold = fold ^ padded[i*32 +: 32];
        end
        sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/fuzz_vec_sequencer.sv
// Buffers input vectors, replays them into two DUT copies and differentially
// checks their outputs, latching the first mismatch and signing the RTL stream.
module fuzz_vec_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DEPTH = 32,
    parameter int LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [IN_W-1:0]            load_data,
    input  logic                       clr,
    input  logic                       start,
    input  logic                       zero_gap,
    output logic [IN_W-1:0]            dut_in,
    input  logic [OUT_W-1:0]           y_a,
    input  logic [OUT_W-1:0]           y_b,
    output logic                       busy,
    output logic                       done,
    output logic                       mismatch,
    output logic [$clog2(DEPTH)-1:0]   mismatch_idx,
    output logic [31:0]                signature,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a load transfers on a rising edge where load_valid && load_ready;
    // load_ready is only offered in IDLE, with room left, and without start/clr.
    seq_state_t      state, state_next;
    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   idx;
    logic            gap_phase;
    logic            zg_l;
    logic [2:0]      drain_cnt;
    seq_tag_t        pipe [LAT+1];
    seq_tag_t        cmp_tag;
    logic            last_vec;
    logic            drain_done;
    logic            write_en;
    logic            run_start;
    logic            unused_tag_bits;

    assign cmp_tag         = pipe[LAT];
    assign unused_tag_bits = ^cmp_tag.idx;
    assign last_vec        = ({1'b0, idx} == (count - CW'(1)));
    assign drain_done      = (drain_cnt == 3'(LAT));
    assign busy            = (state != S_IDLE);
    assign run_start       = (state == S_IDLE) && start;
    assign load_ready      = (state == S_IDLE) && !start && !clr && (count < CW'(DEPTH));
    assign write_en        = load_valid && load_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (count == '0) ? S_DRAIN : S_RUN;
            S_RUN:   if (last_vec && (gap_phase || !zg_l)) state_next = S_DRAIN;
            S_DRAIN: if (drain_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Buffer contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (write_en) mem[count[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dut_in       <= '0;
            count        <= '0;
            idx          <= '0;
            gap_phase    <= 1'b0;
            zg_l         <= 1'b0;
            drain_cnt    <= '0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
            for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
        end else begin
            dut_in  <= '0;
            done    <= 1'b0;
            pipe[0] <= '0;
            for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
            case (state)
                S_IDLE: begin
                    if (start) begin
                        zg_l         <= zero_gap;
                        idx          <= '0;
                        gap_phase    <= 1'b0;
                        drain_cnt    <= '0;
                        mismatch     <= 1'b0;
                        mismatch_idx <= '0;
                    end else if (clr) begin
                        count <= '0;
                    end else if (write_en) begin
                        count <= count + CW'(1);
                    end
                end
                S_RUN: begin
                    drain_cnt <= '0;
                    if (!gap_phase) begin
                        dut_in    <= mem[idx];
                        pipe[0]   <= '{valid: 1'b1, idx: TAG_IDX_W'(idx)};
                        gap_phase <= zg_l;
                        if (!zg_l && !last_vec) idx <= idx + AW'(1);
                    end else begin
                        gap_phase <= 1'b0;
                        if (!last_vec) idx <= idx + AW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (drain_done) done <= 1'b1;
                end
                default: ;
            endcase
            // Compare against the tag that lines up with the current y buses.
            if (!run_start && cmp_tag.valid && (y_a != y_b) && !mismatch) begin
                mismatch     <= 1'b1;
                mismatch_idx <= cmp_tag.idx[AW-1:0];
            end
        end
    end

    sig_misr #(.OUT_W(OUT_W)) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (run_start),
        .en    (cmp_tag.valid),
        .data  (y_a),
        .sig   (signature)
    );

endmodule

// File: tb/tb_fuzz_vec_sequencer.sv
// Self-checking bench for fuzz_vec_sequencer: a registered stand-in DUT feeds
// y_a/y_b, and a scoreboard checks replayed vectors, run length and signature.
module tb_fuzz_vec_sequencer;

    localparam int IN_W  = 76;
    localparam int OUT_W = 240;
    localparam int DEPTH = 32;
    localparam int LAT   = 1;
    localparam int AW    = 5;
    localparam int CW    = 6;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic              clk;
    logic              rst;
    logic              load_valid;
    logic              load_ready;
    logic [IN_W-1:0]   load_data;
    logic              clr;
    logic              start;
    logic              zero_gap;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  y_a;
    logic [OUT_W-1:0]  y_b;
    logic              busy;
    logic              done;
    logic              mismatch;
    logic [AW-1:0]     mismatch_idx;
    logic [31:0]       signature;
    logic [CW-1:0]     count;

    logic [OUT_W-1:0]  y_reg;
    logic              flip_en;
    logic              flip;

    logic [IN_W-1:0]   exp_q[$];
    logic [IN_W-1:0]   vecs[$];
    logic [31:0]       exp_sig;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_total = 0;

    fuzz_vec_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .clr          (clr),
        .start        (start),
        .zero_gap     (zero_gap),
        .dut_in       (dut_in),
        .y_a          (y_a),
        .y_b          (y_b),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx),
        .signature    (signature),
        .count        (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_total++;

    // stand-in DUT with one cycle of latency
    always @(posedge clk) y_reg <= OUT_W'(dut_in);
    assign flip = flip_en && ((y_reg == OUT_W'(2)) || (y_reg == OUT_W'(3)));
    assign y_a  = y_reg;
    assign y_b  = y_reg ^ {{(OUT_W-1){1'b0}}, flip};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sw_fold(input logic [OUT_W-1:0] y);
        logic [OUT_W+31:0] t;
        logic [31:0] r;
        t = {32'h0, y};
        r = 32'h0;
        for (int i = 0; i < OUT_W; i += 32) r = r ^ t[i +: 32];
        return r;
    endfunction

    function automatic logic [31:0] sw_step(input logic [31:0] s, input logic [OUT_W-1:0] y);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ POLY;
        return n ^ sw_fold(y);
    endfunction

    // driver tasks
    task automatic load_vec(input logic [IN_W-1:0] v);
        @(negedge clk);
        load_data  = v;
        load_valid = 1'b1;
        check("load_ready", load_ready, 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        vecs.delete();
    endtask

    task automatic run(input bit zg, input int exp_len, input bit exp_mm, input int exp_idx);
        int c0;
        bit got;
        exp_q.delete();
        exp_sig = 32'h0;
        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i]);
            if (zg) exp_q.push_back('0);
            exp_sig = sw_step(exp_sig, OUT_W'(vecs[i]));
        end
        @(negedge clk);
        start    = 1'b1;
        zero_gap = zg;
        @(posedge clk);
        #1 start = 1'b0;
        c0 = cyc;
        check("busy_rise", busy, 1);
        while (exp_q.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            check("dut_in", dut_in, exp_q.pop_front());
        end
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("run_len", cyc - c0, exp_len);
            check("mismatch", mismatch, exp_mm);
            if (exp_mm) check("mismatch_idx", mismatch_idx, exp_idx);
            check("signature", signature, exp_sig);
            check("busy_at_done", busy, 0);
            @(negedge clk);
            check("done_pulse", done, 0);
        end
    endtask

    initial begin
        int dt;
        bit hit;
        rst = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        clr = 1'b0;
        start = 1'b0;
        zero_gap = 1'b0;
        flip_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dut_in", dut_in, 0);
        check("rst_count", count, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_mm_idx", mismatch_idx, 0);
        check("rst_signature", signature, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_load_ready", load_ready, 1);
        rst = 1'b0;

        // basic replay
        load_vec(76'd1);
        load_vec(76'd2);
        load_vec(76'd3);
        check("count3", count, 3);
        run(0, 5, 0, 0);

        // injected mismatch on vectors 2 and 3
        flip_en = 1'b1;
        run(0, 5, 1, 1);
        flip_en = 1'b0;

        // zero-gap replay, same signature
        run(1, 8, 0, 0);

        // full buffer
        do_clr();
        for (int i = 0; i < DEPTH; i++) load_vec(IN_W'({$urandom, $urandom, $urandom}));
        @(negedge clk);
        check("full_ready", load_ready, 0);
        check("full_count", count, DEPTH);
        load_data  = IN_W'($urandom_range(1, 1000));
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        @(negedge clk);
        check("overflow_count", count, DEPTH);
        run(0, 1 + DEPTH + LAT, 0, 0);

        // clr beats a simultaneous load, then empty replay
        @(negedge clk);
        clr = 1'b1;
        load_valid = 1'b1;
        load_data = IN_W'(5);
        @(posedge clk);
        #1 clr = 1'b0;
        load_valid = 1'b0;
        vecs.delete();
        @(negedge clk);
        check("clr_wins", count, 0);
        run(0, 1 + LAT, 0, 0);

        // reset in the middle of a run
        for (int i = 0; i < 8; i++) load_vec(IN_W'(10 + i));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (dut_in == IN_W'(15)) hit = 1'b1;
        end
        check("reach_vec5", hit, 1);
        dt = done_total;
        rst = 1'b1;
        #1;
        check("mid_rst_dut_in", dut_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_mismatch", mismatch, 0);
        check("mid_rst_signature", signature, 0);
        check("mid_rst_load_ready", load_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vecs.delete();
        repeat (10) @(negedge clk);
        check("no_done_after_rst", done_total, dt);
        check("post_rst_ready", load_ready, 1);
        check("post_rst_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
